// File: rtl/m_control_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// m_control_mem_arbiter_if
//
// Purpose: bundles the fetch-side, LSU-side and memory-side handshake
// signals of the core memory arbiter.
//
// Signal groups:
//   fetch : f_enable, f_addr (requester -> arbiter)
//           f_data, f_ready, f_err (arbiter -> requester)
//   lsu   : l_enable, l_addr, l_we, l_wdata (requester -> arbiter)
//           l_rdata, l_ready, l_err (arbiter -> requester)
//   mem   : m_enable, m_addr, m_we, m_wdata (arbiter -> memory)
//           m_rdata, m_ready (memory -> arbiter)
//
// Modports:
//   slave  : the arbiter's view. It receives requests and drives the memory port.
//   master : the surroundings' view. These are the requesters and the memory.
// ---------------------------------------------------------------------------
interface m_control_mem_arbiter_if;
    logic        f_enable;
    logic [31:0] f_addr;
    logic [31:0] f_data;
    logic        f_ready;
    logic        f_err;

    logic        l_enable;
    logic [31:0] l_addr;
    logic        l_we;
    logic [31:0] l_wdata;
    logic [31:0] l_rdata;
    logic        l_ready;
    logic        l_err;

    logic        m_enable;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    modport slave (
        input  f_enable, f_addr,
        output f_data, f_ready, f_err,
        input  l_enable, l_addr, l_we, l_wdata,
        output l_rdata, l_ready, l_err,
        output m_enable, m_addr, m_we, m_wdata,
        input  m_rdata, m_ready
    );

    modport master (
        output f_enable, f_addr,
        input  f_data, f_ready, f_err,
        output l_enable, l_addr, l_we, l_wdata,
        input  l_rdata, l_ready, l_err,
        input  m_enable, m_addr, m_we, m_wdata,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/m_control_mem_arbiter.sv
// ---------------------------------------------------------------------------
// m_control_mem_arbiter
//
// Purpose: shares the single core memory port between instruction fetch
// and the load/store unit. Only one transaction is in flight at a time.
// Ties are broken round-robin. A transaction that hangs is aborted with an
// error once TIMEOUT cycles pass without m_ready. TIMEOUT = 0 disables the abort.
//
// Ports:
//   clk   : clock. All logic runs on the rising edge.
//   nrst  : asynchronous active-low reset
//   bus   : m_control_mem_arbiter_if.slave. This carries the fetch, LSU and
//           memory handshakes.
// ---------------------------------------------------------------------------
module m_control_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        nrst,
    m_control_mem_arbiter_if.slave      bus
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TLIM = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CW-1:0] CNT_HIT = CW'(TLIM);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_L = 2'd2
    } state_t;

    state_t        state_reg;
    logic          last_grant_l_reg;   // 1: the last grant went to the LSU
    logic [CW-1:0] cnt_reg;

    logic f_elig;
    logic l_elig;
    logic grant_f;
    logic timeout_hit;

    // A requester that is still in its ready cycle has not yet seen the
    // pulse. Its enable is stale, so it must not be re-granted.
    assign f_elig  = bus.f_enable & ~bus.f_ready;
    assign l_elig  = bus.l_enable & ~bus.l_ready;
    assign grant_f = f_elig & (~l_elig | last_grant_l_reg);

    assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_HIT);

    // Taking this from the state register lets it drop with reset at once.
    assign bus.m_enable = (state_reg != IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg        <= IDLE;
            last_grant_l_reg <= 1'b1;
            cnt_reg          <= '0;
            bus.m_addr       <= '0;
            bus.m_we         <= 1'b0;
            bus.m_wdata      <= '0;
            bus.f_data       <= '0;
            bus.f_ready      <= 1'b0;
            bus.f_err        <= 1'b0;
            bus.l_rdata      <= '0;
            bus.l_ready      <= 1'b0;
            bus.l_err        <= 1'b0;
        end else begin
            // The completion pulses last only one cycle.
            bus.f_ready <= 1'b0;
            bus.f_err   <= 1'b0;
            bus.l_ready <= 1'b0;
            bus.l_err   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (grant_f) begin
                        state_reg        <= BUSY_F;
                        bus.m_addr       <= bus.f_addr;
                        bus.m_we         <= 1'b0;
                        bus.m_wdata      <= '0;
                        last_grant_l_reg <= 1'b0;
                        cnt_reg          <= '0;
                    end else if (l_elig) begin
                        state_reg        <= BUSY_L;
                        bus.m_addr       <= bus.l_addr;
                        bus.m_we         <= bus.l_we;
                        bus.m_wdata      <= bus.l_wdata;
                        last_grant_l_reg <= 1'b1;
                        cnt_reg          <= '0;
                    end
                end

                BUSY_F: begin
                    // If m_ready and the timeout come together, m_ready takes
                    // priority.
                    if (bus.m_ready) begin
                        bus.f_data  <= bus.m_rdata;
                        bus.f_ready <= 1'b1;
                        state_reg   <= IDLE;
                    end else if (timeout_hit) begin
                        bus.f_data  <= '0;
                        bus.f_ready <= 1'b1;
                        bus.f_err   <= 1'b1;
                        state_reg   <= IDLE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                BUSY_L: begin
                    if (bus.m_ready) begin
                        // A write returns no data.
                        bus.l_rdata <= bus.m_we ? 32'd0 : bus.m_rdata;
                        bus.l_ready <= 1'b1;
                        state_reg   <= IDLE;
                    end else if (timeout_hit) begin
                        bus.l_rdata <= '0;
                        bus.l_ready <= 1'b1;
                        bus.l_err   <= 1'b1;
                        state_reg   <= IDLE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_control_mem_arbiter.sv
module tb_m_control_mem_arbiter;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_errors;

    m_control_mem_arbiter_if bus();

    m_control_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nrst = 1'b0;
        bus.f_enable = 1'b0; bus.f_addr = '0;
        bus.l_enable = 1'b0; bus.l_addr = '0; bus.l_we = 1'b0; bus.l_wdata = '0;
        bus.m_rdata = '0; bus.m_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_m_enable", {31'd0, bus.m_enable}, 32'd0);
        check("rst_m_addr",   bus.m_addr, 32'd0);
        check("rst_f_ready",  {31'd0, bus.f_ready}, 32'd0);
        check("rst_l_ready",  {31'd0, bus.l_ready}, 32'd0);
        check("rst_f_data",   bus.f_data, 32'd0);

        // After the release, both request and fetch wins the first tie.
        nrst = 1'b1;
        bus.f_enable = 1'b1; bus.f_addr = 32'hA0;
        bus.l_enable = 1'b1; bus.l_addr = 32'hB0;
        tick();
        check("tie_m_enable", {31'd0, bus.m_enable}, 32'd1);
        check("tie_m_addr_f", bus.m_addr, 32'hA0);
        check("tie_m_we",     {31'd0, bus.m_we}, 32'd0);

        // Assert reset in the middle of the busy state.
        #2 nrst = 1'b0;
        #1;
        check("midrst_m_enable", {31'd0, bus.m_enable}, 32'd0);
        check("midrst_m_addr",   bus.m_addr, 32'd0);
        bus.f_enable = 1'b0; bus.l_enable = 1'b0;
        tick();
        check("midrst_f_ready", {31'd0, bus.f_ready}, 32'd0);
        nrst = 1'b1;
        tick();

        // Fetch read. m_ready comes 2 cycles after m_enable.
        bus.f_enable = 1'b1; bus.f_addr = 32'h40;
        tick();
        check("fr_m_enable", {31'd0, bus.m_enable}, 32'd1);
        check("fr_m_addr",   bus.m_addr, 32'h40);
        tick();
        tick();
        bus.m_ready = 1'b1; bus.m_rdata = 32'hDEADBEEF;
        check("fr_no_early_ready", {31'd0, bus.f_ready}, 32'd0);
        tick();
        bus.m_ready = 1'b0; bus.m_rdata = '0;
        check("fr_f_ready",   {31'd0, bus.f_ready}, 32'd1);
        check("fr_f_data",    bus.f_data, 32'hDEADBEEF);
        check("fr_f_err",     {31'd0, bus.f_err}, 32'd0);
        check("fr_m_en_low",  {31'd0, bus.m_enable}, 32'd0);
        bus.f_enable = 1'b0;
        tick();
        check("fr_pulse_1cyc", {31'd0, bus.f_ready}, 32'd0);
        check("fr_data_hold",  bus.f_data, 32'hDEADBEEF);

        // LSU write. Input changes after the grant must be ignored.
        bus.l_enable = 1'b1; bus.l_addr = 32'h100; bus.l_wdata = 32'h12345678; bus.l_we = 1'b1;
        tick();
        check("wr_m_addr",  bus.m_addr, 32'h100);
        check("wr_m_we",    {31'd0, bus.m_we}, 32'd1);
        check("wr_m_wdata", bus.m_wdata, 32'h12345678);
        bus.l_addr = 32'h200; bus.l_wdata = 32'h0;
        tick();
        check("wr_m_addr_hold",  bus.m_addr, 32'h100);
        check("wr_m_wdata_hold", bus.m_wdata, 32'h12345678);
        bus.m_ready = 1'b1; bus.m_rdata = 32'hCAFEF00D;
        tick();
        bus.m_ready = 1'b0;
        check("wr_l_ready", {31'd0, bus.l_ready}, 32'd1);
        check("wr_l_rdata", bus.l_rdata, 32'd0);
        check("wr_l_err",   {31'd0, bus.l_err}, 32'd0);
        bus.l_enable = 1'b0; bus.l_we = 1'b0;
        tick();
        check("wr_pulse_1cyc", {31'd0, bus.l_ready}, 32'd0);

        // Both requesters held continuously. Grants should alternate F, L, F, L.
        bus.f_enable = 1'b1; bus.f_addr = 32'h1F0;
        bus.l_enable = 1'b1; bus.l_addr = 32'h2A0;
        for (int i = 0; i < 4; i++) begin
            logic exp_f;
            exp_f = (i % 2 == 0);
            tick();
            check($sformatf("alt%0d_m_enable", i), {31'd0, bus.m_enable}, 32'd1);
            check($sformatf("alt%0d_m_addr", i), bus.m_addr, exp_f ? 32'h1F0 : 32'h2A0);
            bus.m_ready = 1'b1; bus.m_rdata = 32'h1000 + i;
            tick();
            bus.m_ready = 1'b0;
            check($sformatf("alt%0d_f_ready", i), {31'd0, bus.f_ready}, {31'd0, exp_f});
            check($sformatf("alt%0d_l_ready", i), {31'd0, bus.l_ready}, {31'd0, ~exp_f});
            check($sformatf("alt%0d_data", i), exp_f ? bus.f_data : bus.l_rdata, 32'h1000 + i);
            check($sformatf("alt%0d_m_en_low", i), {31'd0, bus.m_enable}, 32'd0);
        end
        bus.f_enable = 1'b0; bus.l_enable = 1'b0;
        tick();

        // Timeout of 4 on an LSU read. A fetch arrives while the LSU read is busy.
        bus.l_enable = 1'b1; bus.l_addr = 32'h300;
        tick();
        check("to_m_enable", {31'd0, bus.m_enable}, 32'd1);
        check("to_m_addr",   bus.m_addr, 32'h300);
        bus.f_enable = 1'b1; bus.f_addr = 32'h50;
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("to_wait%0d_l_ready", i), {31'd0, bus.l_ready}, 32'd0);
            check($sformatf("to_wait%0d_m_en", i), {31'd0, bus.m_enable}, 32'd1);
        end
        tick();
        check("to_l_ready",  {31'd0, bus.l_ready}, 32'd1);
        check("to_l_err",    {31'd0, bus.l_err}, 32'd1);
        check("to_l_rdata",  bus.l_rdata, 32'd0);
        check("to_m_en_low", {31'd0, bus.m_enable}, 32'd0);
        check("to_f_ready",  {31'd0, bus.f_ready}, 32'd0);
        bus.l_enable = 1'b0;
        tick();
        check("to_next_grant_f", bus.m_addr, 32'h50);
        check("to_next_m_en",    {31'd0, bus.m_enable}, 32'd1);
        check("to_l_err_1cyc",   {31'd0, bus.l_err}, 32'd0);

        // m_ready arrives in the same cycle the counter reaches TIMEOUT-1.
        tick(); tick(); tick();
        bus.m_ready = 1'b1; bus.m_rdata = 32'h0BADF00D;
        check("race_no_ready_yet", {31'd0, bus.f_ready}, 32'd0);
        tick();
        bus.m_ready = 1'b0; bus.m_rdata = '0;
        check("race_f_ready", {31'd0, bus.f_ready}, 32'd1);
        check("race_f_err",   {31'd0, bus.f_err}, 32'd0);
        check("race_f_data",  bus.f_data, 32'h0BADF00D);
        bus.f_enable = 1'b0;
        tick();

        // m_ready while the arbiter is idle has no effect.
        bus.m_ready = 1'b1; bus.m_rdata = 32'h77777777;
        tick();
        bus.m_ready = 1'b0;
        check("idle_mready_f", {31'd0, bus.f_ready}, 32'd0);
        check("idle_mready_l", {31'd0, bus.l_ready}, 32'd0);
        check("idle_f_data",   bus.f_data, 32'h0BADF00D);
        check("idle_m_enable", {31'd0, bus.m_enable}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/m_control_mem_arbiter.md
# m_control_mem_arbiter

Shares the single core memory port between the instruction fetch unit and the load/store unit. Each requester holds a level `enable` plus address (and write data for LSU) until it receives a one-cycle `ready` pulse. The arbiter grants one transaction at a time with round-robin priority, drives the memory port, returns read data, and aborts hung transactions with an error after a programmable timeout. It sits between `m_control_fetch` / LSU and the memory bus.

## Interface
- `TIMEOUT`, default 255: cycles in BUSY without `m_ready` before abort; 0 disables the timeout.
- `clk`  in  1  clock, all logic on rising edge
- `nrst`  in  1  asynchronous, active-low reset
- `f_enable`  in  1  fetch request, held until `f_ready`
- `f_addr`  in  32  fetch address
- `f_data`  out  32  fetch read data, valid while `f_ready`=1
- `f_ready`  out  1  one-cycle completion pulse to fetch
- `f_err`  out  1  qualifies `f_ready`: transaction timed out
- `l_enable`  in  1  LSU request, held until `l_ready`
- `l_addr`  in  32  LSU address
- `l_we`  in  1  1 = write, 0 = read
- `l_wdata`  in  32  LSU write data
- `l_rdata`  out  32  LSU read data, valid while `l_ready`=1 and `l_we` was 0
- `l_ready`  out  1  one-cycle completion pulse to LSU
- `l_err`  out  1  qualifies `l_ready`: transaction timed out
- `m_enable`  out  1  memory request, high for the whole BUSY state
- `m_addr`  out  32  registered memory address
- `m_we`  out  1  registered write strobe
- `m_wdata`  out  32  registered write data
- `m_rdata`  in  32  memory read data, valid with `m_ready`
- `m_ready`  in  1  memory completion

## Operation
- States: IDLE, BUSY_F, BUSY_L. `m_enable` = (state != IDLE).
- Requester eligibility in IDLE: `x_enable`=1 and `x_ready`=0. The pulse cycle is masked because the requester sees `ready` only at the next edge.
- IDLE, one eligible requester: grant it. Both eligible: grant the one not in `last_grant`.
- On grant edge:
  - latch `m_addr`, `m_we`, `m_wdata`; fetch always gets `m_we`=0 and `m_wdata`=0.
  - set `last_grant`; clear the timeout counter.
- BUSY_x with `m_ready`=1:
  - next edge: `x_data`/`x_rdata` <= `m_rdata` (a write returns 0), `x_ready`=1, `x_err`=0, state IDLE.
- BUSY_x, no `m_ready`, `TIMEOUT`>0:
  - counter increments each cycle.
  - when counter = `TIMEOUT`-1, next edge: `x_ready`=1, `x_err`=1, data 0, state IDLE.
- `m_ready` and timeout in the same cycle: `m_ready` wins (normal completion).
- `m_ready` while in IDLE: ignored.
- `x_enable` dropping mid-transaction: the transaction still completes and the pulse is still issued.
- Request inputs are sampled only on the grant edge; later changes are ignored.
- Counter width: $clog2(TIMEOUT+1); saturates and never wraps.

## Timing
- Reset (async) values:
  - state IDLE, `last_grant` = LSU so fetch wins the first tie.
  - counter 0, all outputs 0.
  - `m_enable` falls immediately on `nrst` low, including mid-transaction; no ready pulse is issued.
- Grant latency: request high before edge N gives BUSY from N, with `m_enable`/`m_addr` valid in cycle N.
- Memory completes at cycle N+k (`m_ready` high) → `x_ready` and data at cycle N+k+1 → state IDLE at N+k+1.
- Minimum transaction: 3 cycles of requester `enable`. Back-to-back grants to different requesters: next grant at edge N+k+2.
- `x_ready`, `x_err`: exactly one cycle wide. Data outputs hold their value until the next completion for that requester.
- Never more than one of `f_ready`/`l_ready` high in any cycle.

## Test plan
- Reset: drive `nrst`=0 mid-BUSY → `m_enable`=0 at once, all outputs 0. After release, both requesting → fetch granted first.
- Fetch read, memory `m_ready` 2 cycles after `m_enable`, `m_rdata`=0xDEADBEEF → `f_ready`=1 for one cycle, `f_data`=0xDEADBEEF, `f_err`=0, total 4 cycles.
- Both `f_enable` and `l_enable` held continuously for 4 transactions → grants alternate F,L,F,L. No requester is ever re-granted during its own ready cycle.
- LSU write `l_addr`=0x100, `l_wdata`=0x12345678, `l_we`=1 → `m_addr`=0x100, `m_we`=1, `m_wdata`=0x12345678 held constant until `m_ready`. Then `l_ready`=1, `l_rdata`=0.
- `TIMEOUT`=4, memory never ready → `l_ready`=1, `l_err`=1 exactly 4 cycles after grant. `m_enable` drops the same edge. A pending fetch is granted next.
- `m_ready` asserted on the same cycle the counter hits `TIMEOUT`-1 → normal completion, `x_err`=0, data = `m_rdata`.
